// File: rtl/alu_iter_exec.sv
// ---------------------------------------------------------------------------
// alu_iter_exec : ALU with single-cycle ops and a bit-serial shifter
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module alu_iter_exec #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_control,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            branch_taken,
  output logic            illegal
);

  localparam logic [3:0] c_ADD  = 4'b0000;
  localparam logic [3:0] c_SUB  = 4'b0001;
  localparam logic [3:0] c_AND  = 4'b0010;
  localparam logic [3:0] c_OR   = 4'b0011;
  localparam logic [3:0] c_XOR  = 4'b0100;
  localparam logic [3:0] c_SLT  = 4'b0101;
  localparam logic [3:0] c_SLL  = 4'b0110;
  localparam logic [3:0] c_SRL  = 4'b0111;
  localparam logic [3:0] c_BLT  = 4'b1000;
  localparam logic [3:0] c_BGE  = 4'b1001;
  localparam logic [3:0] c_BLTU = 4'b1010;
  localparam logic [3:0] c_BGEU = 4'b1011;
  localparam logic [3:0] c_BEQ  = 4'b1100;
  localparam logic [3:0] c_BNE  = 4'b1101;
  localparam logic [3:0] c_SRA  = 4'b1110;
  localparam logic [3:0] c_SLTU = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [3:0]      r_ctrl;
  logic [XLEN-1:0] r_shreg;
  logic [4:0]      r_cnt;
  logic [XLEN-1:0] r_result;
  logic            r_branch;
  logic            r_illegal;

  logic [XLEN-1:0] w_res;
  logic            w_cond;
  logic            w_is_branch;
  logic            w_is_shift;
  logic            w_illegal;
  logic [4:0]      w_shamt;
  logic            w_shift_start;
  logic [XLEN-1:0] w_shift_next;

  assign w_shamt       = src_b[4:0];
  assign w_shift_start = w_is_shift && (w_shamt != 5'd0);

  always_comb begin
    w_res       = '0;
    w_cond      = 1'b0;
    w_is_branch = 1'b0;
    w_is_shift  = 1'b0;
    w_illegal   = 1'b0;
    case (alu_control)
      c_ADD:  w_res = src_a + src_b;
      c_SUB:  w_res = src_a - src_b;
      c_AND:  w_res = src_a & src_b;
      c_OR:   w_res = src_a | src_b;
      c_XOR:  w_res = src_a ^ src_b;
      c_SLT:  w_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      c_SLTU: w_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
      // Zero shift amount completes immediately with the operand unchanged
      c_SLL, c_SRL, c_SRA: begin
        w_is_shift = 1'b1;
        w_res      = src_a;
      end
      c_BLT:  begin w_is_branch = 1'b1; w_cond = ($signed(src_a) <  $signed(src_b)); end
      c_BGE:  begin w_is_branch = 1'b1; w_cond = ($signed(src_a) >= $signed(src_b)); end
      c_BLTU: begin w_is_branch = 1'b1; w_cond = (src_a <  src_b); end
      c_BGEU: begin w_is_branch = 1'b1; w_cond = (src_a >= src_b); end
      c_BEQ:  begin w_is_branch = 1'b1; w_cond = (src_a == src_b); end
      c_BNE:  begin w_is_branch = 1'b1; w_cond = (src_a != src_b); end
      default: w_illegal = 1'b1;
    endcase
    if (w_is_branch) begin
      w_res = {{(XLEN-1){1'b0}}, w_cond};
    end
  end

  always_comb begin
    case (r_ctrl)
      c_SLL:   w_shift_next = {r_shreg[XLEN-2:0], 1'b0};
      c_SRL:   w_shift_next = {1'b0, r_shreg[XLEN-1:1]};
      default: w_shift_next = {r_shreg[XLEN-1], r_shreg[XLEN-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_next = w_shift_start ? S_SHIFT : S_DONE;
        end
      end
      S_SHIFT: begin
        if (r_cnt == 5'd1) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl    <= 4'd0;
      r_shreg   <= '0;
      r_cnt     <= 5'd0;
      r_result  <= '0;
      r_branch  <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_ctrl    <= alu_control;
            r_shreg   <= src_a;
            r_cnt     <= w_shift_start ? w_shamt : 5'd0;
            r_branch  <= w_shift_start ? 1'b0 : w_cond;
            r_illegal <= w_shift_start ? 1'b0 : w_illegal;
            if (!w_shift_start) begin
              r_result <= w_res;
            end
          end
        end
        S_SHIFT: begin
          r_shreg <= w_shift_next;
          r_cnt   <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_result <= w_shift_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign result       = r_result;
  assign zero         = (r_result == '0);
  assign branch_taken = r_branch;
  assign illegal      = r_illegal;

endmodule

`default_nettype wire

// File: doc/alu_iter_exec.md
ALU_ITER_EXEC -- requirements
Module: alu_iter_exec

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; only 32 is required to be supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operation request valid.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request this cycle.
REQ-006 SHALL have port alu_control  input  4  operation code, as produced by the ALU decoder.
REQ-007 SHALL have port src_a  input  XLEN  operand A (rs1).
REQ-008 SHALL have port src_b  input  XLEN  operand B (rs2 or immediate); bits [4:0] are the shift amount.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  XLEN  operation result.
REQ-012 SHALL have port zero  output  1  result == 0.
REQ-013 SHALL have port branch_taken  output  1  branch condition true (branch codes only).
REQ-014 SHALL have port illegal  output  1  alu_control was not a defined code.

Function
REQ-015 SHALL decode alu_control: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed), 1111 SLTU, 0110 SLL, 0111 SRL, 1110 SRA, 1000 BLT, 1001 BGE, 1010 BLTU, 1011 BGEU, 1100 BEQ, 1101 BNE.
REQ-016 SHALL use an FSM with states IDLE, SHIFT, DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-017 SHALL accept a request on a rising edge where in_valid & in_ready, capturing alu_control, src_a, src_b; inputs are ignored at all other times.
REQ-018 For non-shift codes, accept SHALL move IDLE->DONE with result registered; out_valid rises the cycle after accept (latency 1).
REQ-019 For shift codes with shamt = src_b[4:0] = n > 0, accept SHALL move IDLE->SHIFT, load src_a into a shift register and n into a 5-bit counter.
REQ-020 In SHIFT, each cycle SHALL shift one bit (SLL: zero fill at LSB; SRL: zero fill at MSB; SRA: replicate bit 31) and decrement the counter; on the cycle the counter goes 1->0 the state SHALL move to DONE; out_valid rises n+1 cycles after accept.
REQ-021 Shift with n = 0 SHALL go IDLE->DONE with result = src_a (latency 1).
REQ-022 ADD/SUB SHALL be modulo 2^32, no overflow flag; SLT/SLTU SHALL yield 32'd1 or 32'd0.
REQ-023 Branch codes SHALL set result = {31'b0, cond} and branch_taken = cond; for all non-branch codes branch_taken SHALL be 0.
REQ-024 zero SHALL equal (result == 0) whenever out_valid is 1.
REQ-025 Undefined codes (none remain with 4 bits, but X/Z or future codes) SHALL produce result 0, illegal = 1, latency 1; otherwise illegal = 0.
REQ-026 In DONE, result, zero, branch_taken, illegal SHALL hold stable until out_valid & out_ready; then the state SHALL return to IDLE next cycle (no back-to-back accept in the same edge).
REQ-027 in_valid asserted during SHIFT or DONE SHALL have no effect; the requester must hold it until in_ready.

Reset
REQ-028 When rst = 1 at a rising edge, state SHALL become IDLE, counter 0, result 0, zero 1, branch_taken 0, illegal 0, out_valid 0, in_ready 1 from the next cycle.
REQ-029 Reset mid-SHIFT or in DONE SHALL abort the operation; the pending result is discarded and no out_valid pulse follows.
REQ-030 rst SHALL take priority over in_valid and out_ready on the same edge.

Verification
REQ-031 ADD 0x7FFFFFFF + 0x1, out_ready=1 -> out_valid 1 cycle after accept, result 0x80000000, zero 0; SUB 5-5 -> result 0, zero 1.
REQ-032 SRA src_a=0x80000000, src_b=31 -> out_valid 32 cycles after accept, result 0xFFFFFFFF; SRL same operands -> 0x00000001; SLL shamt 0 -> result = src_a, latency 1.
REQ-033 BLT -1 vs 1 -> branch_taken 1; BLTU 0xFFFFFFFF vs 1 -> branch_taken 0; BEQ 7 vs 7 -> 1, BNE 7 vs 7 -> 0.
REQ-034 Backpressure: out_ready held 0 for 5 cycles after result -> outputs stable, in_ready 0, new in_valid ignored; release -> IDLE next cycle.
REQ-035 Assert rst during SHIFT of a shamt-20 operation -> in_ready 1, out_valid 0 next cycle, no later result.
